// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the 32-point radix-2 FFT stage sequencer.
// Counter widths are derived with clog2 so that a latency of 1 still gets a 1-bit counter.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    OUTLD = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int FFT_POINTS     = 32;
  localparam int NUM_STAGES_DEF = 5;

  // Minimum width is 1, so a single-cycle counter still has a real register bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fft_lat_counter.sv
// Modulo-LAT wait counter for the butterfly settle time of one stage.
// tc_o marks the last settle cycle; the counter wraps to 0 on the next enabled edge.
module fft_lat_counter
  import fft_ctrl_pkg::*;
#(
  parameter int LAT = 1,
  parameter int W   = clog2(LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // With LAT=1 the terminal count is 0, so the counter never leaves 0.
  assign tc_o = (cnt_q == W'(LAT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for the FFT register pipeline: accepts a frame, walks the one-hot
// stage enables, loads the output register file and holds it until the sink takes it.
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STAGE_LAT  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ABORT,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  EN_IN,
  output logic [NUM_STAGES-1:0] EN_STG,
  output logic                  EN_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [2:0]            STAGE_IDX,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      FRAME_CNT
);

  localparam int STG_W = clog2(NUM_STAGES);

  state_e             state_q, state_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               in_run;
  logic               wait_tc;
  logic               last_stage;

  assign in_run     = (state_q == RUN);
  assign last_stage = (stage_q == STG_W'(NUM_STAGES - 1));

  fft_lat_counter #(
    .LAT (STAGE_LAT)
  ) u_wait (
    .clk   (CLK),
    .rst   (RST),
    .clr_i (ABORT | ~in_run),
    .en_i  (in_run),
    .tc_o  (wait_tc)
  );

  // Input capture is the only same-cycle path; it must not fire under abort or reset.
  assign IN_READY  = (state_q == IDLE);
  assign EN_IN     = IN_VALID & IN_READY & ~ABORT & ~RST;
  assign EN_OUT    = (state_q == OUTLD) & ~ABORT;
  assign OUT_VALID = (state_q == HOLD);
  assign BUSY      = (state_q != IDLE);
  assign STAGE_IDX = in_run ? 3'(stage_q) : 3'd0;
  assign FRAME_CNT = frame_cnt_q;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stg_en
      assign EN_STG[gi] = in_run & wait_tc & ~ABORT & (stage_q == STG_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (EN_IN) begin
          state_d = RUN;
          stage_d = '0;
        end
      end
      RUN: begin
        if (wait_tc) begin
          if (last_stage) begin
            state_d = OUTLD;
            stage_d = '0;
          end else begin
            stage_d = stage_q + STG_W'(1);
          end
        end
      end
      OUTLD: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (OUT_READY) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
    // Abort discards the frame in flight, including a handshake in the same cycle.
    if (ABORT) begin
      state_d     = IDLE;
      stage_d     = '0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: three instances (latency 1, latency 3,
// 2-bit frame counter) driven one after another from a single linear sequence.
module tb_fft_stage_ctrl;

  localparam int NS = 5;

  logic clk;
  logic rst;

  logic a_ab, a_iv, a_ir, a_en_in, a_en_out, a_ov, a_or, a_busy;
  logic [NS-1:0] a_stg;
  logic [2:0]    a_idx;
  logic [15:0]   a_cnt;

  logic b_ab, b_iv, b_ir, b_en_in, b_en_out, b_ov, b_or, b_busy;
  logic [NS-1:0] b_stg;
  logic [2:0]    b_idx;
  logic [15:0]   b_cnt;

  logic w_ab, w_iv, w_ir, w_en_in, w_en_out, w_ov, w_or, w_busy;
  logic [NS-1:0] w_stg;
  logic [2:0]    w_idx;
  logic [1:0]    w_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  fft_stage_ctrl #(.NUM_STAGES(NS), .STAGE_LAT(1), .CNT_W(16)) dut_a (
    .CLK(clk), .RST(rst), .ABORT(a_ab), .IN_VALID(a_iv), .IN_READY(a_ir),
    .EN_IN(a_en_in), .EN_STG(a_stg), .EN_OUT(a_en_out), .OUT_VALID(a_ov),
    .OUT_READY(a_or), .STAGE_IDX(a_idx), .BUSY(a_busy), .FRAME_CNT(a_cnt)
  );

  fft_stage_ctrl #(.NUM_STAGES(NS), .STAGE_LAT(3), .CNT_W(16)) dut_b (
    .CLK(clk), .RST(rst), .ABORT(b_ab), .IN_VALID(b_iv), .IN_READY(b_ir),
    .EN_IN(b_en_in), .EN_STG(b_stg), .EN_OUT(b_en_out), .OUT_VALID(b_ov),
    .OUT_READY(b_or), .STAGE_IDX(b_idx), .BUSY(b_busy), .FRAME_CNT(b_cnt)
  );

  fft_stage_ctrl #(.NUM_STAGES(NS), .STAGE_LAT(1), .CNT_W(2)) dut_w (
    .CLK(clk), .RST(rst), .ABORT(w_ab), .IN_VALID(w_iv), .IN_READY(w_ir),
    .EN_IN(w_en_in), .EN_STG(w_stg), .EN_OUT(w_en_out), .OUT_VALID(w_ov),
    .OUT_READY(w_or), .STAGE_IDX(w_idx), .BUSY(w_busy), .FRAME_CNT(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {EN_IN, EN_STG[4:0], EN_OUT, OUT_VALID, IN_READY, BUSY, STAGE_IDX[2:0]}
  function automatic logic [12:0] ev(logic en_in, logic [4:0] stg, logic en_out,
                                     logic ov, logic ir, logic busy, logic [2:0] idx);
    return {en_in, stg, en_out, ov, ir, busy, idx};
  endfunction

  // Expected outputs c cycles after acceptance, from the documented latencies.
  function automatic logic [12:0] exp_at(int c, int lat);
    logic [4:0] s;
    s = '0;
    if (c == 0) return ev(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    if (c <= NS * lat) begin
      if (c % lat == 0) s = 5'(1 << (c / lat - 1));
      return ev(1'b0, s, 1'b0, 1'b0, 1'b0, 1'b1, 3'((c - 1) / lat));
    end
    if (c == NS * lat + 1) return ev(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    return ev(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
  endfunction

  function automatic logic [12:0] idle_vec();
    return ev(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic en_in, input logic [4:0] stg,
                          input logic en_out, input logic ov, input logic ir,
                          input logic busy, input logic [2:0] idx, input logic [12:0] exp);
    chk(tag, 32'({en_in, stg, en_out, ov, ir, busy, idx}), 32'(exp));
    chk({tag, "_onehot"}, 32'($onehot0(stg)), 32'd1);
    chk({tag, "_excl"}, 32'((int'(en_in) + int'(|stg) + int'(en_out)) <= 1), 32'd1);
  endtask

  task automatic chk_a(input string tag, input logic [12:0] exp);
    chk_outs(tag, a_en_in, a_stg, a_en_out, a_ov, a_ir, a_busy, a_idx, exp);
  endtask

  task automatic chk_b(input string tag, input logic [12:0] exp);
    chk_outs(tag, b_en_in, b_stg, b_en_out, b_ov, b_ir, b_busy, b_idx, exp);
  endtask

  task automatic chk_w(input string tag, input logic [12:0] exp);
    chk_outs(tag, w_en_in, w_stg, w_en_out, w_ov, w_ir, w_busy, w_idx, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_ab = 1'b0; a_iv = 1'b1; a_or = 1'b0;
    b_ab = 1'b0; b_iv = 1'b1; b_or = 1'b0;
    w_ab = 1'b0; w_iv = 1'b1; w_or = 1'b0;

    // Reset held with IN_VALID high: nothing captured, IN_READY by IDLE decode.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk_a($sformatf("rst_a_%0d", i), idle_vec());
      chk_b($sformatf("rst_b_%0d", i), idle_vec());
      chk_w($sformatf("rst_w_%0d", i), idle_vec());
      chk($sformatf("rst_cnt_a_%0d", i), 32'(a_cnt), 32'd0);
      chk($sformatf("rst_cnt_w_%0d", i), 32'(w_cnt), 32'd0);
    end
    rst = 1'b0; a_iv = 1'b0; b_iv = 1'b0; w_iv = 1'b0;

    // Single frame, latency 1, sink always ready.
    a_or = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      next_cycle(); a_iv = (c == 0); #1;
      chk_a($sformatf("single_c%0d", c), exp_at(c, 1));
    end
    next_cycle(); a_iv = 1'b0; #1;
    chk_a("single_idle", idle_vec());
    chk("single_cnt", 32'(a_cnt), 32'd1);
    $display("A single frame done, FRAME_CNT=%0d", a_cnt);

    // Abort in RUN cycle 3: no stage enable, back to IDLE, count unchanged.
    for (int c = 0; c <= 3; c++) begin
      next_cycle(); a_iv = (c == 0); a_ab = (c == 3); #1;
      if (c < 3) chk_a($sformatf("abort_c%0d", c), exp_at(c, 1));
      else       chk_a("abort_c3", ev(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2));
    end
    $display("A frame aborted in RUN");

    // Back-to-back frames; the first accept lands right after the abort.
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c <= 7; c++) begin
        next_cycle(); a_ab = 1'b0; a_iv = 1'b1; #1;
        chk_a($sformatf("b2b_f%0d_c%0d", f, c), exp_at(c, 1));
        if (c == 0) chk($sformatf("b2b_cnt_f%0d", f), 32'(a_cnt), 32'(1 + f));
      end
      $display("A back-to-back frame %0d handshaken", f);
    end
    next_cycle(); a_iv = 1'b0; #1;
    chk_a("b2b_idle", idle_vec());
    chk("b2b_cnt_end", 32'(a_cnt), 32'd4);

    // Abort in HOLD together with OUT_READY: no count.
    for (int c = 0; c <= 7; c++) begin
      next_cycle(); a_iv = (c == 0); a_ab = (c == 7); #1;
      chk_a($sformatf("hold_abort_c%0d", c), exp_at(c, 1));
    end
    next_cycle(); a_ab = 1'b0; #1;
    chk_a("hold_abort_idle", idle_vec());
    chk("hold_abort_cnt", 32'(a_cnt), 32'd4);
    $display("A frame aborted in HOLD, FRAME_CNT=%0d", a_cnt);

    // Reset mid-RUN: immediate return to reset state.
    for (int c = 0; c <= 2; c++) begin
      next_cycle(); a_iv = (c == 0); #1;
      chk_a($sformatf("midrst_c%0d", c), exp_at(c, 1));
    end
    next_cycle(); rst = 1'b1; #1;
    chk_a("midrst_in_rst", idle_vec());
    chk("midrst_cnt", 32'(a_cnt), 32'd0);
    next_cycle(); rst = 1'b0; #1;
    chk_a("midrst_after", idle_vec());
    $display("A frame discarded by reset");

    // Latency 3 with the sink stalled for 10 cycles in HOLD.
    for (int c = 0; c <= 27; c++) begin
      next_cycle(); b_iv = (c == 0); b_or = (c == 27); #1;
      chk_b($sformatf("lat3_c%0d", c), exp_at(c, 3));
      if (c == 26) chk("lat3_cnt_stall", 32'(b_cnt), 32'd0);
    end
    next_cycle(); b_or = 1'b0; #1;
    chk_b("lat3_idle", idle_vec());
    chk("lat3_cnt", 32'(b_cnt), 32'd1);
    $display("B frame done, FRAME_CNT=%0d", b_cnt);

    // 2-bit frame counter wraps: 1, 2, 3, 0, 1.
    w_or = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c <= 7; c++) begin
        next_cycle(); w_iv = 1'b1; #1;
        chk_w($sformatf("wrap_f%0d_c%0d", f, c), exp_at(c, 1));
        if (c == 0 && f > 0) chk($sformatf("wrap_cnt_f%0d", f), 32'(w_cnt), 32'(f % 4));
      end
      $display("W frame %0d handshaken", f);
    end
    next_cycle(); w_iv = 1'b0; #1;
    chk_w("wrap_idle", idle_vec());
    chk("wrap_cnt_end", 32'(w_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
